// File: rtl/uart_rx_fifo.sv
// rtl/uart_rx_fifo.sv - UART receiver with parity/framing checks and a show-ahead receive FIFO
module uart_rx_fifo #(
   parameter int CLK_FREQ   = 66_000_000,
   parameter int BAUD_RATE  = 9600,
   parameter int DATA_BITS  = 8,
   parameter int PARITY     = 0,
   parameter int STOP_BITS  = 1,
   parameter int FIFO_DEPTH = 16
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          rx,
   input  logic                          rd_en,
   input  logic                          clr_err,
   output logic [DATA_BITS-1:0]          data,
   output logic                          perr,
   output logic                          ferr,
   output logic                          dr,
   output logic [$clog2(FIFO_DEPTH):0]   count,
   output logic                          overrun
);

   localparam int BIT_TIME = CLK_FREQ / BAUD_RATE;
   localparam int CW       = $clog2(BIT_TIME);
   localparam int IW       = $clog2(DATA_BITS + 1);
   localparam int PW       = $clog2(FIFO_DEPTH);
   localparam int NW       = PW + 1;
   localparam int EW       = DATA_BITS + 2;

   localparam logic [CW-1:0] HALF_LOAD = CW'(BIT_TIME / 2 - 1);
   localparam logic [CW-1:0] FULL_LOAD = CW'(BIT_TIME - 1);
   localparam logic [IW-1:0] LAST_DATA = IW'(DATA_BITS - 1);
   localparam logic [IW-1:0] LAST_STOP = IW'(STOP_BITS - 1);
   localparam logic [NW-1:0] DEPTH_C   = NW'(FIFO_DEPTH);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_START,
      ST_DATA,
      ST_PARITY,
      ST_STOP,
      ST_WAIT_HIGH
   } state_t;

   logic                 meta_q, rxs_q;
   state_t               state_q;
   logic [CW-1:0]        cnt_q;
   logic [IW-1:0]        idx_q;
   logic [DATA_BITS-1:0] shreg_q;
   logic                 perr_q, ferr_q;

   logic [EW-1:0]        mem_q [FIFO_DEPTH];
   logic [PW-1:0]        wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]        rd_ptr_q, rd_ptr_d;
   logic [NW-1:0]        count_q, count_d;
   logic                 overrun_q, overrun_d;

   logic                 frame_ferr, push, pop, push_ok;
   logic [EW-1:0]        push_entry, head;

   // Two-flop synchronizer; idle-high reset value so reset never looks like a start bit
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         meta_q <= 1'b1;
         rxs_q  <= 1'b1;
      end else begin
         meta_q <= rx;
         rxs_q  <= meta_q;
      end
   end

   // Framing error for the current frame includes the stop sample being taken right now
   assign frame_ferr = ferr_q | ~rxs_q;
   assign push       = (state_q == ST_STOP) && (cnt_q == '0) && (idx_q == LAST_STOP);
   assign push_entry = {frame_ferr, perr_q, shreg_q};

   // Receive FSM: mid-bit sampling driven by a reloadable down-counter
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         idx_q   <= '0;
         shreg_q <= '0;
         perr_q  <= 1'b0;
         ferr_q  <= 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (!rxs_q) begin
                  cnt_q   <= HALF_LOAD;
                  state_q <= ST_START;
               end
            end
            ST_START: begin
               if (cnt_q != '0) begin
                  cnt_q <= cnt_q - 1'b1;
               end else if (rxs_q) begin
                  state_q <= ST_IDLE;
               end else begin
                  cnt_q   <= FULL_LOAD;
                  idx_q   <= '0;
                  shreg_q <= '0;
                  perr_q  <= 1'b0;
                  ferr_q  <= 1'b0;
                  state_q <= ST_DATA;
               end
            end
            ST_DATA: begin
               if (cnt_q != '0) begin
                  cnt_q <= cnt_q - 1'b1;
               end else begin
                  // LSB first: after DATA_BITS shifts the first bit sits at bit 0
                  shreg_q <= {rxs_q, shreg_q[DATA_BITS-1:1]};
                  cnt_q   <= FULL_LOAD;
                  if (idx_q == LAST_DATA) begin
                     idx_q   <= '0;
                     state_q <= (PARITY != 0) ? ST_PARITY : ST_STOP;
                  end else begin
                     idx_q <= idx_q + 1'b1;
                  end
               end
            end
            ST_PARITY: begin
               if (cnt_q != '0) begin
                  cnt_q <= cnt_q - 1'b1;
               end else begin
                  perr_q  <= (PARITY == 1) ? ~(^shreg_q ^ rxs_q) : (^shreg_q ^ rxs_q);
                  cnt_q   <= FULL_LOAD;
                  state_q <= ST_STOP;
               end
            end
            ST_STOP: begin
               if (cnt_q != '0) begin
                  cnt_q <= cnt_q - 1'b1;
               end else begin
                  ferr_q <= frame_ferr;
                  if (idx_q == LAST_STOP) begin
                     idx_q   <= '0;
                     state_q <= frame_ferr ? ST_WAIT_HIGH : ST_IDLE;
                  end else begin
                     idx_q <= idx_q + 1'b1;
                     cnt_q <= FULL_LOAD;
                  end
               end
            end
            ST_WAIT_HIGH: begin
               if (rxs_q) state_q <= ST_IDLE;
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   // FIFO next state; a pop frees the slot a same-cycle push needs when full
   always_comb begin
      pop       = rd_en && (count_q != '0);
      push_ok   = push && ((count_q != DEPTH_C) || pop);
      wr_ptr_d  = push_ok ? wr_ptr_q + 1'b1 : wr_ptr_q;
      rd_ptr_d  = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
      count_d   = count_q;
      if (push_ok && !pop) count_d = count_q + 1'b1;
      else if (!push_ok && pop) count_d = count_q - 1'b1;
      overrun_d = overrun_q;
      if (push && !push_ok) overrun_d = 1'b1;
      else if (clr_err) overrun_d = 1'b0;
   end

   // FIFO pointers, occupancy and sticky overrun
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         count_q   <= '0;
         overrun_q <= 1'b0;
      end else begin
         wr_ptr_q  <= wr_ptr_d;
         rd_ptr_q  <= rd_ptr_d;
         count_q   <= count_d;
         overrun_q <= overrun_d;
      end
   end

   // Storage array; contents are only visible through the occupancy gate below
   always_ff @(posedge clk) begin
      if (push_ok) mem_q[wr_ptr_q] <= push_entry;
   end

   assign head    = mem_q[rd_ptr_q];
   assign dr      = (count_q != '0);
   assign data    = dr ? head[DATA_BITS-1:0] : '0;
   assign perr    = dr & head[DATA_BITS] & (PARITY != 0);
   assign ferr    = dr & head[DATA_BITS+1];
   assign count   = count_q;
   assign overrun = overrun_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb/tb_uart_rx_fifo.sv - directed bench for uart_rx_fifo (8N1 and 7E1 instances)
module tb_uart_rx_fifo;

   localparam int BT = 10;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst_n_a, rx_a, rd_en_a, clr_a;
   logic [7:0] data_a;
   logic       perr_a, ferr_a, dr_a, ovr_a;
   logic [2:0] count_a;

   logic       rst_n_b, rx_b, rd_en_b, clr_b;
   logic [6:0] data_b;
   logic       perr_b, ferr_b, dr_b, ovr_b;
   logic [2:0] count_b;

   int n_checks = 0;
   int n_errors = 0;

   uart_rx_fifo #(
      .CLK_FREQ(1_000_000), .BAUD_RATE(100_000), .DATA_BITS(8),
      .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(4)
   ) u_a (
      .clk(clk), .rst_n(rst_n_a), .rx(rx_a), .rd_en(rd_en_a), .clr_err(clr_a),
      .data(data_a), .perr(perr_a), .ferr(ferr_a), .dr(dr_a),
      .count(count_a), .overrun(ovr_a)
   );

   uart_rx_fifo #(
      .CLK_FREQ(1_000_000), .BAUD_RATE(100_000), .DATA_BITS(7),
      .PARITY(2), .STOP_BITS(1), .FIFO_DEPTH(4)
   ) u_b (
      .clk(clk), .rst_n(rst_n_b), .rx(rx_b), .rd_en(rd_en_b), .clr_err(clr_b),
      .data(data_b), .perr(perr_b), .ferr(ferr_b), .dr(dr_b),
      .count(count_b), .overrun(ovr_b)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic send_a(input logic [7:0] v);
      logic [9:0] f;
      f = {1'b1, v, 1'b0};
      for (int i = 0; i < 10; i++) begin
         rx_a = f[i];
         repeat (BT) @(negedge clk);
      end
   endtask

   task automatic send_b(input logic [6:0] v, input logic p);
      logic [9:0] f;
      f = {1'b1, p, v, 1'b0};
      for (int i = 0; i < 10; i++) begin
         rx_b = f[i];
         repeat (BT) @(negedge clk);
      end
   endtask

   task automatic pop_a();
      rd_en_a = 1'b1;
      @(negedge clk);
      rd_en_a = 1'b0;
   endtask

   task automatic pop_b();
      rd_en_b = 1'b1;
      @(negedge clk);
      rd_en_b = 1'b0;
   endtask

   initial begin
      logic [9:0] pf;
      rst_n_a = 1'b0; rx_a = 1'b1; rd_en_a = 1'b0; clr_a = 1'b0;
      rst_n_b = 1'b0; rx_b = 1'b1; rd_en_b = 1'b0; clr_b = 1'b0;
      repeat (3) @(negedge clk);

      check("rst_data",  32'(data_a),  32'h0);
      check("rst_perr",  32'(perr_a),  32'h0);
      check("rst_ferr",  32'(ferr_a),  32'h0);
      check("rst_dr",    32'(dr_a),    32'h0);
      check("rst_count", 32'(count_a), 32'h0);
      check("rst_ovr",   32'(ovr_a),   32'h0);
      check("rst_dr_b",  32'(dr_b),    32'h0);

      rst_n_a = 1'b1; rst_n_b = 1'b1;
      repeat (5) @(negedge clk);

      // Basic 8N1 frame
      send_a(8'hA5);
      check("a5_dr",    32'(dr_a),    32'h1);
      check("a5_data",  32'(data_a),  32'hA5);
      check("a5_perr",  32'(perr_a),  32'h0);
      check("a5_ferr",  32'(ferr_a),  32'h0);
      check("a5_count", 32'(count_a), 32'h1);
      pop_a();
      check("a5_pop_dr",    32'(dr_a),    32'h0);
      check("a5_pop_count", 32'(count_a), 32'h0);
      check("a5_pop_data",  32'(data_a),  32'h0);

      // Even parity, 7 data bits: 0x03 has two ones
      send_b(7'h03, 1'b0);
      send_b(7'h03, 1'b1);
      repeat (5) @(negedge clk);
      check("par_count", 32'(count_b), 32'h2);
      check("par0_data", 32'(data_b),  32'h03);
      check("par0_perr", 32'(perr_b),  32'h0);
      pop_b();
      check("par1_data", 32'(data_b),  32'h03);
      check("par1_perr", 32'(perr_b),  32'h1);
      pop_b();
      check("par_empty", 32'(dr_b),    32'h0);

      // Line break then a normal frame
      rx_a = 1'b0;
      repeat (20 * BT) @(negedge clk);
      rx_a = 1'b1;
      repeat (BT) @(negedge clk);
      send_a(8'h5A);
      repeat (5) @(negedge clk);
      check("brk_count", 32'(count_a), 32'h2);
      check("brk_data",  32'(data_a),  32'h00);
      check("brk_ferr",  32'(ferr_a),  32'h1);
      pop_a();
      check("brk2_data", 32'(data_a),  32'h5A);
      check("brk2_ferr", 32'(ferr_a),  32'h0);
      pop_a();
      check("brk_empty", 32'(count_a), 32'h0);

      // Glitch shorter than half a bit
      rx_a = 1'b0;
      repeat (3) @(negedge clk);
      rx_a = 1'b1;
      repeat (2 * BT) @(negedge clk);
      check("glitch_count", 32'(count_a), 32'h0);
      check("glitch_dr",    32'(dr_a),    32'h0);
      send_a(8'h3C);
      repeat (2) @(negedge clk);
      check("post_glitch_count", 32'(count_a), 32'h1);
      check("post_glitch_data",  32'(data_a),  32'h3C);
      pop_a();

      // Overrun with depth 4
      for (int v = 1; v <= 5; v++) send_a(8'(v));
      repeat (2) @(negedge clk);
      check("ovf_count", 32'(count_a), 32'h4);
      check("ovf_flag",  32'(ovr_a),   32'h1);
      for (int v = 1; v <= 4; v++) begin
         check($sformatf("ovf_pop%0d", v), 32'(data_a), 32'(v));
         pop_a();
      end
      check("ovf_drained", 32'(count_a), 32'h0);
      check("ovf_sticky",  32'(ovr_a),   32'h1);
      clr_a = 1'b1;
      @(negedge clk);
      clr_a = 1'b0;
      check("ovf_clr", 32'(ovr_a), 32'h0);

      // Refill, then pop on the push edge of a fifth frame
      for (int v = 8'h11; v <= 8'h14; v++) send_a(8'(v));
      check("refill_count", 32'(count_a), 32'h4);
      fork
         send_a(8'h15);
         begin
            repeat (97) @(negedge clk);
            rd_en_a = 1'b1;
            @(negedge clk);
            rd_en_a = 1'b0;
            check("pushpop_count", 32'(count_a), 32'h4);
            check("pushpop_ovr",   32'(ovr_a),   32'h0);
         end
      join
      for (int v = 8'h12; v <= 8'h15; v++) begin
         check($sformatf("pushpop_data%0h", v), 32'(data_a), 32'(v));
         pop_a();
      end
      check("pushpop_empty", 32'(count_a), 32'h0);

      // Reset in the middle of data bit 3 with two entries stored
      send_a(8'h77);
      send_a(8'h88);
      check("prerst_count", 32'(count_a), 32'h2);
      pf = {1'b1, 8'h99, 1'b0};
      for (int i = 0; i < 4; i++) begin
         rx_a = pf[i];
         repeat (BT) @(negedge clk);
      end
      rx_a = pf[4];
      repeat (5) @(negedge clk);
      rst_n_a = 1'b0;
      #1;
      check("midrst_dr",    32'(dr_a),    32'h0);
      check("midrst_count", 32'(count_a), 32'h0);
      check("midrst_data",  32'(data_a),  32'h0);
      check("midrst_ferr",  32'(ferr_a),  32'h0);
      check("midrst_ovr",   32'(ovr_a),   32'h0);
      @(negedge clk);
      rst_n_a = 1'b1;
      rx_a = 1'b1;
      repeat (3 * BT) @(negedge clk);
      send_a(8'hC3);
      repeat (2) @(negedge clk);
      check("postrst_count", 32'(count_a), 32'h1);
      check("postrst_data",  32'(data_a),  32'hC3);
      pop_a();
      check("postrst_empty", 32'(dr_a), 32'h0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule

// File: doc/uart_rx_fifo.md
# uart_rx_fifo

Parametrised UART receiver with a built-in receive FIFO. It is the successor to the single-byte, CPU-gated receiver. Frames are received continuously, with no `go` handshake, at a configurable data width, parity mode and stop-bit count. Each received word is stored together with its parity-error and framing-error flags, and the CPU drains the FIFO through a show-ahead pop interface. The block sits between the board RX pin and the CPU's UART I/O registers.

## Interface
- `CLK_FREQ`, 66_000_000, system clock frequency in Hz.
- `BAUD_RATE`, 9600, line rate. `BIT_TIME = CLK_FREQ / BAUD_RATE` (integer division) must be ≥ 4.
- `DATA_BITS`, 8, data bits per frame, 5..9, sent LSB first.
- `PARITY`, 0, parity mode: 0 = none, 1 = odd, 2 = even.
- `STOP_BITS`, 1, stop bits per frame, 1 or 2.
- `FIFO_DEPTH`, 16, number of entries; a power of two, ≥ 2.
- `clk`  in  1  system clock; all state changes on its rising edge.
- `rst_n`  in  1  reset; asynchronous, active-low.
- `rx`  in  1  serial line; asynchronous to `clk`; idles high.
- `rd_en`  in  1  pop the head entry. Ignored when `dr` = 0.
- `clr_err`  in  1  one-cycle pulse that clears `overrun`.
- `data`  out  DATA_BITS  head entry data; 0 when the FIFO is empty.
- `perr`  out  1  head entry parity error; 0 when empty or when `PARITY` = 0.
- `ferr`  out  1  head entry framing error; 0 when empty.
- `dr`  out  1  FIFO not empty.
- `count`  out  $clog2(FIFO_DEPTH)+1  number of stored entries.
- `overrun`  out  1  sticky flag: at least one frame was dropped because the FIFO was full.

## Operation
- `rx` passes through a 2-flop synchronizer. Both flops reset to 1. All sampling below uses the synchronized value, `rxs`.
- Bit counter width is `$clog2(BIT_TIME)`. Bit index width is `$clog2(DATA_BITS+1)`.
- FSM states: IDLE, START, DATA, PARITY, STOP, WAIT_HIGH. The state register resets to IDLE.
- **IDLE**
  - When `rxs` = 0: load counter with `BIT_TIME/2 - 1`, go to START.
- **START**
  - Count down. At 0, sample `rxs`.
  - If `rxs` = 1, the low pulse was a glitch: go to IDLE and push nothing.
  - If `rxs` = 0: load counter with `BIT_TIME - 1`, clear the bit index, go to DATA.
- **DATA**
  - At each counter 0, shift in the sample at the current bit index and reload the counter.
  - After sample `DATA_BITS-1`, go to PARITY if `PARITY` ≠ 0, otherwise go to STOP.
- **PARITY**
  - At counter 0, sample the parity bit.
  - Set `perr` when the XOR of the data bits and the parity bit ≠ 1 (odd) or ≠ 0 (even).
- **STOP**
  - Sample once per stop bit. Any low stop sample sets `ferr`.
  - At the final stop sample, push the entry `{ferr, perr, data}`.
  - If `ferr` = 0, go to IDLE in the same edge; the next start edge can be detected from the middle of the stop bit.
  - If `ferr` = 1, go to WAIT_HIGH.
- **WAIT_HIGH**
  - Stay until `rxs` = 1, then go to IDLE.
  - A line break therefore produces exactly one entry (data 0, `ferr` = 1).
- **FIFO**
  - Circular buffer with `$clog2(FIFO_DEPTH)`-bit read and write pointers that wrap modulo the depth. `count` tracks occupancy.
  - A push is accepted when `count < FIFO_DEPTH`, or when a pop happens in the same cycle.
  - If a push is not accepted, the frame is dropped and `overrun` is set.
  - A pop with `dr` = 0 is ignored. A simultaneous push and pop leaves `count` unchanged.
- **Overrun flag**
  - `clr_err` clears `overrun`.
  - If a set and a clear happen in the same cycle, the set wins.

## Timing
- Reset values: `data` = 0, `perr` = 0, `ferr` = 0, `dr` = 0, `count` = 0, `overrun` = 0, FSM in IDLE, pointers = 0.
- Reset asserted mid-frame discards the partial frame and all FIFO contents.
- The synchronizer adds 2 cycles of latency from `rx` to `rxs`.
- Push happens at the final stop-bit sample edge. `dr`, `count`, `data` and the flags are valid from the next cycle.
- Frame latency is about 2 + `BIT_TIME/2` + (`DATA_BITS` + parity + `STOP_BITS`) × `BIT_TIME` cycles after the falling edge of `rx`.
- Show-ahead read: while `dr` = 1, the head entry is on `data`/`perr`/`ferr`. After a `rd_en` cycle, the next entry (or zeros) appears the following cycle.
- Outputs are registered or driven from the registered FIFO; there is no combinational path from `rx` to any output.

## Test plan
- Default 8N1, `BIT_TIME` = 10 (`CLK_FREQ` = 1_000_000, `BAUD_RATE` = 100_000): send 0xA5.
  - `dr` rises within 100 cycles with `data` = 0xA5, `perr` = `ferr` = 0, `count` = 1.
  - Pulse `rd_en` for one cycle: `dr` = 0, `count` = 0, `data` = 0.
- `PARITY` = 2, `DATA_BITS` = 7: send 0x03 with parity bit 0, then 0x03 with parity bit 1.
  - Two entries: `perr` = 0, then `perr` = 1. `data` = 0x03 for both.
- Break: hold `rx` low for 20 bit times, then release high, then send 0x5A.
  - Exactly two entries: (0x00, `ferr` = 1), then (0x5A, `ferr` = 0).
- Glitch: drive `rx` low for 3 cycles (under `BIT_TIME/2`).
  - No entry is pushed and the FSM returns to IDLE. A frame sent afterwards is received correctly.
- `FIFO_DEPTH` = 4: send 0x01..0x05 without reading.
  - `count` = 4, `overrun` = 1, and pops return 0x01..0x04.
  - `clr_err` clears `overrun`.
  - Refill to full, then assert `rd_en` on the push cycle of a 5th frame: the frame is accepted, `count` stays 4, `overrun` stays 0.
- Reset: pulse `rst_n` low during data bit 3 with 2 entries stored.
  - All outputs go to 0 immediately. The next full frame 0xC3 is received as the only entry.
